// File: rtl/accum_mem_responder.sv
// Word-array memory that answers 4B val/rdy memory requests in order.
// Read data is captured at acceptance and held in a small response FIFO.
package accum_mem_pkg;
  localparam logic [2:0] MEM_REQ_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_REQ_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module accum_mem_responder
  import accum_mem_pkg::*;
#(
  parameter int NUM_WORDS    = 256,
  parameter int RESP_Q_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  mem_req_4B_t  mem_reqstream_msg,
  input  logic         mem_reqstream_val,
  output logic         mem_reqstream_rdy,
  output mem_resp_4B_t mem_respstream_msg,
  output logic         mem_respstream_val,
  input  logic         mem_respstream_rdy
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int PW = $clog2(RESP_Q_DEPTH);
  localparam int CW = $clog2(RESP_Q_DEPTH + 1);

  logic [31:0]  mem [NUM_WORDS];
  mem_resp_4B_t resp_q [RESP_Q_DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          rdy_q;
  logic          enq, deq;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [2:0]    size, avail, nbytes;
  logic [4:0]    nmask;
  logic [3:0]    bmask;
  logic [31:0]   wmask, word, rd_data, wr_word;
  mem_resp_4B_t  resp_new;
  logic          unused_addr;

  assign unused_addr = ^mem_reqstream_msg.addr[31:AW+2];

  // rdy_q holds the request side off while reset is low and for the release cycle
  assign mem_reqstream_rdy  = rdy_q && (count < CW'(RESP_Q_DEPTH));
  assign enq                = mem_reqstream_val && mem_reqstream_rdy;
  assign mem_respstream_val = (count != '0);
  assign deq                = mem_respstream_val && mem_respstream_rdy;
  assign mem_respstream_msg = mem_respstream_val ? resp_q[head] : '0;

  always_comb begin
    idx    = mem_reqstream_msg.addr[AW+1:2];
    lane   = mem_reqstream_msg.addr[1:0];
    size   = (mem_reqstream_msg.len == 2'd0) ? 3'd4 : {1'b0, mem_reqstream_msg.len};
    avail  = 3'd4 - {1'b0, lane};
    nbytes = (size > avail) ? avail : size;
    // byte enables clipped at the word boundary, then moved to the lane
    nmask  = (5'h1 << nbytes) - 5'h1;
    bmask  = nmask[3:0] << lane;
    wmask  = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    word   = mem[idx];
    rd_data = (word & wmask) >> {lane, 3'b000};
    wr_word = (word & ~wmask) | ((mem_reqstream_msg.data << {lane, 3'b000}) & wmask);

    resp_new        = '0;
    resp_new.type_  = mem_reqstream_msg.type_;
    resp_new.opaque = mem_reqstream_msg.opaque;
    resp_new.len    = mem_reqstream_msg.len;
    if (mem_reqstream_msg.type_ == MEM_REQ_TYPE_READ)
      resp_new.data = rd_data;
  end

  always_ff @(posedge clk) begin
    if (enq && (mem_reqstream_msg.type_ == MEM_REQ_TYPE_WRITE))
      mem[idx] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (enq)
      resp_q[tail] <= resp_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (enq)
        tail <= (tail == PW'(RESP_Q_DEPTH - 1)) ? '0 : tail + PW'(1);
      if (deq)
        head <= (head == PW'(RESP_Q_DEPTH - 1)) ? '0 : head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_accum_mem_responder.sv
// Directed bench for accum_mem_responder with an in-order response scoreboard.
module tb_accum_mem_responder;
  import accum_mem_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  mem_req_4B_t  req_msg;
  logic         req_val, req_rdy;
  mem_resp_4B_t resp_msg;
  logic         resp_val, resp_rdy;

  int           vectors = 0, miscompares = 0, cycle = 0, st;
  mem_resp_4B_t sb [$];
  int           pop_cyc [$];
  mem_resp_4B_t exp_r;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  accum_mem_responder #(.NUM_WORDS(256), .RESP_Q_DEPTH(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_reqstream_msg  (req_msg),
    .mem_reqstream_val  (req_val),
    .mem_reqstream_rdy  (req_rdy),
    .mem_respstream_msg (resp_msg),
    .mem_respstream_val (resp_val),
    .mem_respstream_rdy (resp_rdy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every transferred response must match the oldest expectation
  always @(negedge clk) begin
    if (resp_val && resp_rdy) begin
      if (sb.size() == 0) begin
        check("resp_with_empty_scoreboard", 64'(resp_val), 64'd0);
      end else begin
        exp_r = sb.pop_front();
        check("resp_msg", 64'(resp_msg), 64'(exp_r));
        pop_cyc.push_back(cycle);
      end
    end
    if (!resp_val) check("idle_msg_zero", 64'(resp_msg), 64'd0);
  end

  task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d, input logic [31:0] exp_d,
                      output int stalls);
    mem_resp_4B_t e;
    stalls  = 0;
    req_msg = '{type_: t, opaque: op, addr: a, len: l, data: d};
    req_val = 1'b1;
    @(negedge clk);
    while (!req_rdy && stalls < 40) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_rdy) check("req_accept_timeout", 64'(req_rdy), 64'd1);
    e = '0;
    e.type_ = t; e.opaque = op; e.len = l; e.data = exp_d;
    sb.push_back(e);
    @(posedge clk); #1;
    req_val = 1'b0;
    req_msg = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
    #1;
  endtask

  initial begin
    req_val = 1'b0; req_msg = '0; resp_rdy = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst_req_rdy", 64'(req_rdy), 64'd0);
    check("rst_resp_val", 64'(resp_val), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 check("release_req_rdy_still_low", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    check("release_req_rdy_high", 64'(req_rdy), 64'd1);

    // write then read back, response one cycle after acceptance
    send(MEM_REQ_TYPE_WRITE, 8'h01, 32'h1000, 2'd0, 32'h5, 32'h0, st);
    send(MEM_REQ_TYPE_READ,  8'h3A, 32'h1000, 2'd0, 32'h0, 32'h5, st);
    check("read_latency_val", 64'(resp_val), 64'd1);
    check("read_latency_data", 64'(resp_msg.data), 64'h5);
    drain();

    for (int i = 0; i < 8; i++)
      send(MEM_REQ_TYPE_WRITE, 8'(i), 32'(i * 4), 2'd0, 32'(i + 1), 32'h0, st);
    drain();
    pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      send(MEM_REQ_TYPE_READ, 8'(8'h40 + i), 32'(i * 4), 2'd0, 32'h0, 32'(i + 1), st);
      check("b2b_no_stall", 64'(st), 64'd0);
    end
    drain();
    check("b2b_resp_count", 64'(pop_cyc.size()), 64'd8);
    check("b2b_consecutive", 64'(pop_cyc[7] - pop_cyc[0]), 64'd7);

    // backpressure: two fit, third waits until a slot frees
    resp_rdy = 1'b0;
    send(MEM_REQ_TYPE_READ, 8'h50, 32'h8, 2'd0, 32'h0, 32'h3, st);
    send(MEM_REQ_TYPE_READ, 8'h51, 32'hC, 2'd0, 32'h0, 32'h4, st);
    check("bp_rdy_low_full", 64'(req_rdy), 64'd0);
    req_msg = '{type_: MEM_REQ_TYPE_READ, opaque: 8'h52, addr: 32'h10, len: 2'd0, data: 32'h0};
    req_val = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold_rdy_low", 64'(req_rdy), 64'd0);
    end
    @(posedge clk); #1 resp_rdy = 1'b1;
    @(negedge clk);
    check("bp_rdy_low_same_cycle", 64'(req_rdy), 64'd0);
    @(posedge clk); #1;
    check("bp_rdy_rises_next_cycle", 64'(req_rdy), 64'd1);
    exp_r = '0; exp_r.type_ = MEM_REQ_TYPE_READ; exp_r.opaque = 8'h52; exp_r.data = 32'h5;
    sb.push_back(exp_r);
    @(posedge clk); #1;
    req_val = 1'b0; req_msg = '0;
    drain();

    // subword access and word-boundary truncation
    send(MEM_REQ_TYPE_WRITE, 8'h60, 32'h20, 2'd0, 32'hAABBCCDD, 32'h0, st);
    send(MEM_REQ_TYPE_WRITE, 8'h61, 32'h22, 2'd1, 32'hFFFFFF11, 32'h0, st);
    send(MEM_REQ_TYPE_READ,  8'h62, 32'h20, 2'd0, 32'h0, 32'hAA11CCDD, st);
    send(MEM_REQ_TYPE_READ,  8'h63, 32'h22, 2'd2, 32'h0, 32'h0000AA11, st);
    send(MEM_REQ_TYPE_READ,  8'h64, 32'h23, 2'd2, 32'h0, 32'h000000AA, st);
    send(MEM_REQ_TYPE_READ,  8'h65, 32'h21, 2'd3, 32'h0, 32'h00AA11CC, st);
    send(3'd3,               8'h66, 32'h20, 2'd0, 32'hDEADBEEF, 32'h0, st);
    send(MEM_REQ_TYPE_READ,  8'h67, 32'h20, 2'd0, 32'h0, 32'hAA11CCDD, st);
    drain();

    // address wrap modulo 4*NUM_WORDS
    send(MEM_REQ_TYPE_WRITE, 8'h68, 32'h400, 2'd0, 32'h1234, 32'h0, st);
    send(MEM_REQ_TYPE_READ,  8'h69, 32'h0, 2'd0, 32'h0, 32'h1234, st);
    send(MEM_REQ_TYPE_READ,  8'h6A, 32'hFFFFFC00, 2'd0, 32'h0, 32'h1234, st);
    drain();

    // asynchronous reset with two responses stalled
    resp_rdy = 1'b0;
    send(MEM_REQ_TYPE_READ, 8'h70, 32'h20, 2'd0, 32'h0, 32'hAA11CCDD, st);
    send(MEM_REQ_TYPE_READ, 8'h71, 32'h4, 2'd0, 32'h0, 32'h2, st);
    check("pre_reset_val", 64'(resp_val), 64'd1);
    #3 reset = 1'b0;
    #1;
    check("mid_reset_val_drops", 64'(resp_val), 64'd0);
    check("mid_reset_rdy_low", 64'(req_rdy), 64'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("post_reset_rdy", 64'(req_rdy), 64'd1);
    check("post_reset_val", 64'(resp_val), 64'd0);
    resp_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no_stale_resp", 64'(resp_val), 64'd0);
    end
    @(posedge clk); #1;
    send(MEM_REQ_TYPE_READ, 8'h72, 32'h20, 2'd0, 32'h0, 32'hAA11CCDD, st);
    send(MEM_REQ_TYPE_READ, 8'h73, 32'h1C, 2'd0, 32'h0, 32'h8, st);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/accum_mem_responder.md
Name: accum_mem_responder

Overview:
- Single-port word-array memory acting as the responder end of the 4B val/rdy memory request/response protocol.
- Accepts `mem_req_4B_t` requests (read/write), performs the access on an internal array, and returns `mem_resp_4B_t` responses in order.
- Serves as the synthesizable scratchpad and test memory behind accumulator-style initiators; also usable as a stand-alone bench memory.

Parameters:
- NUM_WORDS, 256, number of 32-bit words; must be a power of 2 and ≥ 2.
- RESP_Q_DEPTH, 2, response buffer entries; must be ≥ 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-low: asserts immediately when low, released synchronously to clk.
- mem_reqstream_msg  input  $bits(mem_req_4B_t)  request: type_, opaque, addr, len, data.
- mem_reqstream_val  input  1  request valid.
- mem_reqstream_rdy  output  1  request ready.
- mem_respstream_msg  output  $bits(mem_resp_4B_t)  response: type_, opaque, len, data.
- mem_respstream_val  output  1  response valid.
- mem_respstream_rdy  input  1  response ready.

Behaviour:
- Handshake: a transfer occurs on any cycle where val && rdy on the same rising edge. rdy never depends combinationally on val.
- mem_reqstream_rdy = (occupancy of response buffer < RESP_Q_DEPTH). It has no combinational path from mem_respstream_rdy.
- Latency: a request accepted at edge N produces mem_respstream_val high in cycle N+1 at the earliest. With mem_respstream_rdy held high, throughput is 1 request/cycle and occupancy never exceeds 1.
- Ordering: responses leave strictly in request-acceptance order. The response buffer is a FIFO.
- Address decode:
  - word index = addr[log2(NUM_WORDS)+1:2]; upper bits are ignored, so addresses wrap modulo 4*NUM_WORDS.
  - byte lane = addr[1:0].
- len encoding: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = 3 bytes.
- Accesses must not cross a word boundary. If lane + size > 4, the access is truncated at the word boundary.
- READ (type_ = `VC_MEM_REQ_MSG_TYPE_READ`): resp.data = word >> (8*lane), masked to size bytes, zero-extended.
- WRITE (type_ = `VC_MEM_REQ_MSG_TYPE_WRITE`): only the addressed bytes are updated, with req.data low bytes written starting at the lane. resp.data = 0.
- Any other type_: no array update; resp.data = 0.
- Response fields: type_, opaque, and len are echoed from the request; all other fields are 0.
- Read data is captured at acceptance edge N into the buffer entry. It is unaffected by later writes, even when a response stalls.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1.
- 4-state hygiene: mem_respstream_msg is forced to all zeros whenever mem_respstream_val is low.
- Simultaneous enq/deq at full occupancy: rdy was low in that cycle, so no enq occurs. Occupancy drops by 1 and rdy rises in the next cycle.
- Reset (reset low, including mid-operation):
  - response buffer emptied; mem_respstream_val = 0; mem_reqstream_rdy = 0 while reset is held, then 1 in the first cycle after release.
  - array contents are NOT reset, and no write is performed while reset is low.
  - in-flight responses are discarded.
- Line trace (non-synthesis): "req|state-occupancy|resp", using the val/rdy trace helpers.

Test Plan:
- Write 0x0000_0005 to addr 0x1000, then read 0x1000 with opaque 0x3A.
  → Write response: type_ WRITE, data 0.
  → Read response: type_ READ, opaque 0x3A, data 0x0000_0005, valid exactly 1 cycle after read acceptance.
- Preload words 0..7 with 1..8, then issue 8 back-to-back reads with resp_rdy = 1.
  → 8 responses in 8 consecutive cycles, data 1..8 in order, rdy never drops.
- Backpressure: resp_rdy = 0, issue 3 reads.
  → First 2 accepted; rdy low at occupancy 2; third accepted the cycle after resp_rdy rises. Data order preserved.
- Subword:
  - write word 0xAABBCCDD to 0x20;
  - byte-write 0x11 to 0x22 (len 1);
  - read 0x20 (len 0) → 0xAA11CCDD;
  - halfword read at 0x22 (len 2) → 0x0000AA11.
- Wrap: with NUM_WORDS = 256, write 0x1234 to 0x400, read 0x0 → 0x1234.
- Reset mid-stream: 2 responses buffered under backpressure, pulse reset low asynchronously.
  → val drops immediately; no stale response after release.
  → A read of a previously written address returns the preserved data.
